inv_round_seq: RTL

INV_ROUND_SEQ -- requirements
Module: inv_round_seq

---
 rtl/inv_round_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/inv_round_seq.sv
// rtl/inv_round_seq.sv - iterative inverse round sequencer (key, inverse S-box, inverse pbox0)
module inv_round_seq #(
  parameter int SBOX_LAT   = 1,
  parameter int MAX_ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   num_rounds,
  input  logic [639:0] state_in,
  output logic [4:0]   key_idx,
  input  logic [19:0]  roundkey,
  output logic         busy,
  output logic         done,
  output logic [639:0] state_out
);

  typedef enum logic [2:0] {IDLE, KEY, SBOX, PB0, FIN} state_t;

  localparam logic [4:0] MAX_R     = 5'(MAX_ROUNDS);
  localparam logic [1:0] SBOX_LAST = 2'(SBOX_LAT - 1);

  state_t         state, state_nx;
  logic [4:0]     rcnt;
  logic [1:0]     scnt;
  logic [639:0]   working;
  logic [4:0]     clamped;
  logic [639:0]   key_mix;
  logic [639:0]   sbox_out;
  logic [639:0]   pb0_out;

  // Undo the forward word rotations: 64-bit word i was rotated left by 6*i+1.
  function automatic logic [639:0] inv_rot(input logic [639:0] x);
    logic [639:0] y;
    logic [63:0]  w;
    y = '0;
    for (int i = 0; i < 10; i++) begin
      w = x[64*i +: 64];
      y[64*i +: 64] = (w >> (6*i + 1)) | (w << (63 - 6*i));
    end
    return y;
  endfunction

  // Undo pbox1: the forward word permutation moved word i to word (3*i+1) mod 10.
  function automatic logic [639:0] inv_pbox1(input logic [639:0] x);
    logic [639:0] y;
    y = '0;
    for (int i = 0; i < 10; i++) begin
      y[64*i +: 64] = x[64*((3*i + 1) % 10) +: 64];
    end
    return y;
  endfunction

  // Undo pbox0: the forward bit permutation moved bit k to bit (7*k) mod 640.
  function automatic logic [639:0] inv_pbox0(input logic [639:0] x);
    logic [639:0] y;
    y = '0;
    for (int k = 0; k < 640; k++) begin
      y[k] = x[(k*7) % 640];
    end
    return y;
  endfunction

  // Lane a forward S-box is 5*x+0x63 (mod 256); 205 is the inverse of 5.
  function automatic logic [7:0] inv_sbox_a(input logic [7:0] y);
    logic [7:0] t;
    t = y - 8'h63;
    return t * 8'd205;
  endfunction

  // Lane b forward S-box is 13*x+0x1F (mod 256); 197 is the inverse of 13.
  function automatic logic [7:0] inv_sbox_b(input logic [7:0] y);
    logic [7:0] t;
    t = y - 8'h1F;
    return t * 8'd197;
  endfunction

  // Round count clamping and per-state datapath results.
  always_comb begin
    clamped  = (num_rounds > MAX_R) ? MAX_R : num_rounds;
    key_mix  = inv_pbox1(inv_rot(working ^ {32{roundkey}}));
    sbox_out = {working[639:16], inv_sbox_b(working[15:8]), inv_sbox_a(working[7:0])};
    pb0_out  = inv_pbox0(working);
  end

  // Keys are consumed from rcnt-1 down to 0; parked at 0 when no rounds remain.
  assign key_idx = (rcnt == 5'd0) ? 5'd0 : rcnt - 5'd1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and status outputs; busy covers only the round states.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (clamped == 5'd0) ? FIN : KEY;
      KEY: begin
        busy     = 1'b1;
        state_nx = SBOX;
      end
      SBOX: begin
        busy = 1'b1;
        if (scnt == SBOX_LAST) state_nx = PB0;
      end
      PB0: begin
        busy     = 1'b1;
        state_nx = (rcnt == 5'd1) ? FIN : KEY;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working state, round/latency counters, and result register.
  // The result is captured on entry to FIN so it is valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      working   <= '0;
      rcnt      <= '0;
      scnt      <= '0;
      state_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          working <= state_in;
          rcnt    <= clamped;
          scnt    <= '0;
          if (clamped == 5'd0) state_out <= state_in;
        end
        KEY: begin
          working <= key_mix;
          scnt    <= '0;
        end
        SBOX: begin
          if (scnt == SBOX_LAST) begin
            working <= sbox_out;
            scnt    <= '0;
          end else begin
            scnt <= scnt + 2'd1;
          end
        end
        PB0: begin
          working <= pb0_out;
          rcnt    <= rcnt - 5'd1;
          if (rcnt == 5'd1) state_out <= pb0_out;
        end
        default: ;
      endcase
    end
  end

endmodule
